regfile_wbq: RTL and testbench
==============================

REGFILE_WBQ -- requirements
Module: regfile_wbq

Interface
REQ-001 SHALL have parameter DATA, default 32, the data width of one writeback entry.
REQ-002 SHALL have parameter ADDR, default 4, the register address width.
REQ-003 SHALL have parameter SRC, default 2, the number of writeback producers (1..8).
REQ-004 SHALL have parameter DEPTH, default 4, the queue entries (power of 2, 2..16).
REQ-005 SHALL have parameter ZERO_REG, default 0; when 1, register 0 is hard-wired zero.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-low reset: reset==0 at a rising clk edge resets the block.
REQ-008 SHALL have port src_valid, input, [SRC-1:0], the per-producer writeback request.
REQ-009 SHALL have port src_addr, input, [SRC-1:0][ADDR-1:0], the per-producer destination register.
REQ-010 SHALL have port src_data, input, [SRC-1:0][DATA-1:0], the per-producer write data.
REQ-011 SHALL have port src_ready, input-side handshake output, [SRC-1:0], asserted to the accepted producer.
REQ-012 SHALL have port stall, input, 1, which blocks draining this cycle (regfile write port borrowed).
REQ-013 SHALL have port we, output, 1, the regfile write enable.
REQ-014 SHALL have port waddr, output, [ADDR-1:0], the regfile write address.
REQ-015 SHALL have port wdata, output, [DATA-1:0], the regfile write data.
REQ-016 SHALL have port count, output, [$clog2(DEPTH):0], the current occupancy.
REQ-017 SHALL have port q_addr, input, [ADDR-1:0], the forwarding lookup address.
REQ-018 SHALL have ports q_hit, output, 1, and q_data, output, [DATA-1:0], the forwarding result.

Function
REQ-019 SHALL be a circular FIFO of {addr,data} with read/write pointers of width log2(DEPTH)+1 and wrap-around modulo DEPTH.
REQ-020 SHALL pick a winner each cycle as the lowest-index producer with src_valid=1 (fixed priority); at most one push per cycle.
REQ-021 SHALL assert src_ready only for the winner, and only when count<DEPTH or a pop occurs in the same cycle (full+pop accepts).
REQ-022 SHALL combinationally drive we = (count!=0) && !stall, with waddr/wdata taken from the head entry; a pop occurs exactly when we=1.
REQ-023 SHALL make a pushed entry visible at the head no earlier than the cycle after the push (no same-cycle bypass to we).
REQ-024 SHALL drain entries in exact acceptance order; count SHALL update as +push-pop each cycle.
REQ-025 SHALL, when ZERO_REG=1, accept (assert src_ready) a winner with src_addr=0 but not enqueue it; count is unchanged by it.
REQ-026 SHALL hold src_ready=0 for all producers when no producer is valid, and never assert more than one src_ready bit.
REQ-027 SHALL keep we=0 whenever count==0, regardless of stall.

Reset
REQ-028 SHALL, on reset==0 at a rising edge, clear both pointers and count to 0, discarding all queued entries, including any mid-drain.
REQ-029 SHALL drive we=0, src_ready=0, q_hit=0 and q_data=0 during the reset cycle; waddr/wdata are don't-care while we=0.
REQ-030 SHALL ignore src_valid in the cycle reset==0 (no push is recorded).

Configuration
REQ-031 SHALL implement forwarding only when macro REGFILE_WBQ_FWD_EN is defined.
REQ-032 SHALL, with REGFILE_WBQ_FWD_EN defined, drive q_hit=1 and q_data from the youngest queued entry whose addr==q_addr, combinationally, excluding entries pushed this cycle; with ZERO_REG=1, q_addr=0 SHALL give q_hit=0.
REQ-033 SHALL, without REGFILE_WBQ_FWD_EN, tie q_hit=0 and q_data=0; ports remain present.

Verification
REQ-034 SHALL cover reset: after reset==0 with 3 entries queued -> count=0, we=0 next cycle, queued data never written.
REQ-035 SHALL cover arbitration: src_valid=2'b11, addr 5/7, data 0xA/0xB, stall=0 -> src_ready=01 then 10; we at addr 5 data 0xA, then addr 7 data 0xB.
REQ-036 SHALL cover full/stall: DEPTH=4, stall=1, push 4 entries -> count=4, src_ready=0; stall=0 with a valid push -> pop and push same cycle, count stays 4.
REQ-037 SHALL cover the zero register: ZERO_REG=1, push addr 0 data 0xFF -> src_ready=1, count stays 0, we never asserted.
REQ-038 SHALL cover forwarding (REGFILE_WBQ_FWD_EN): stall=1, push addr 3 data 0x11 then addr 3 data 0x22 -> q_addr=3 gives q_hit=1, q_data=0x22; without the macro -> q_hit=0.
REQ-039 SHALL cover wrap-around: 10 push/pop cycles on DEPTH=4 with data 1..10 -> wdata sequence 1..10 in order with no loss.

Source files
------------

// File: rtl/regfile_wbq.sv
// Writeback queue in front of a single regfile write port: fixed-priority intake, in-order drain.
// Optional forwarding lookup over queued entries is built when REGFILE_WBQ_FWD_EN is defined.
module regfile_wbq #(
  parameter int DATA     = 32,
  parameter int ADDR     = 4,
  parameter int SRC      = 2,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SRC-1:0]            src_valid,
  input  logic [SRC-1:0][ADDR-1:0]  src_addr,
  input  logic [SRC-1:0][DATA-1:0]  src_data,
  output logic [SRC-1:0]            src_ready,
  input  logic                      stall,
  output logic                      we,
  output logic [ADDR-1:0]           waddr,
  output logic [DATA-1:0]           wdata,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [ADDR-1:0]           q_addr,
  output logic                      q_hit,
  output logic [DATA-1:0]           q_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SRC > 1) ? $clog2(SRC) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR-1:0] mem_addr [DEPTH];
  logic [DATA-1:0] mem_data [DEPTH];

  logic [CW-1:0]   wr_ptr_p1;
  logic [CW-1:0]   rd_ptr_p1;
  logic [CW-1:0]   count_p1;

  logic            win_vld_p0;
  logic [SW-1:0]   win_idx_p0;
  logic [ADDR-1:0] win_addr_p0;
  logic [DATA-1:0] win_data_p0;
  logic            accept_p0;
  logic            zero_drop_p0;
  logic            push_p0;
  logic            pop_p0;

  // Stage p0: arbitration and drain decision
  always_comb begin
    win_vld_p0 = 1'b0;
    win_idx_p0 = '0;
    for (int i = SRC - 1; i >= 0; i--) begin
      if (src_valid[i]) begin
        win_vld_p0 = 1'b1;
        win_idx_p0 = SW'(i);
      end
    end
  end

  assign win_addr_p0  = src_addr[win_idx_p0];
  assign win_data_p0  = src_data[win_idx_p0];

  assign pop_p0       = reset && (count_p1 != '0) && !stall;
  assign accept_p0    = reset && win_vld_p0 && ((count_p1 != FULL) || pop_p0);
  // Writes to a hard-wired zero register are acknowledged but never reach the regfile.
  assign zero_drop_p0 = (ZERO_REG != 0) && (win_addr_p0 == '0);
  assign push_p0      = accept_p0 && !zero_drop_p0;

  always_comb begin
    src_ready = '0;
    if (accept_p0) src_ready[win_idx_p0] = 1'b1;
  end

  assign we    = pop_p0;
  assign waddr = mem_addr[rd_ptr_p1[AW-1:0]];
  assign wdata = mem_data[rd_ptr_p1[AW-1:0]];
  assign count = count_p1;

  // Stage p1: queue control state
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_p1 <= '0;
      rd_ptr_p1 <= '0;
      count_p1  <= '0;
    end else begin
      if (push_p0) wr_ptr_p1 <= wr_ptr_p1 + CW'(1);
      if (pop_p0)  rd_ptr_p1 <= rd_ptr_p1 + CW'(1);
      count_p1 <= count_p1 + CW'(push_p0) - CW'(pop_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      mem_addr[wr_ptr_p1[AW-1:0]] <= win_addr_p0;
      mem_data[wr_ptr_p1[AW-1:0]] <= win_data_p0;
    end
  end

`ifdef REGFILE_WBQ_FWD_EN
  logic            fwd_hit;
  logic [DATA-1:0] fwd_data;
  logic [AW-1:0]   fwd_idx;

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_p1[AW-1:0] + AW'(i);
      if ((CW'(i) < count_p1) && (mem_addr[fwd_idx] == q_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[fwd_idx];
      end
    end
    if ((ZERO_REG != 0) && (q_addr == '0)) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
    if (!reset) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end

  assign q_hit  = fwd_hit;
  assign q_data = fwd_data;
`else
  logic unused_q_addr;
  assign unused_q_addr = ^q_addr;
  assign q_hit  = 1'b0;
  assign q_data = '0;
`endif

endmodule

// File: tb/tb_regfile_wbq.sv
// Bench for regfile_wbq: directed scenarios plus random traffic against a queue-based reference.
module tb_regfile_wbq;

  localparam int DATA = 32;
  localparam int ADDR = 4;
  localparam int SRC  = 2;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [SRC-1:0]           src_valid;
  logic [SRC-1:0][ADDR-1:0] src_addr;
  logic [SRC-1:0][DATA-1:0] src_data;
  logic [SRC-1:0]           src_ready;
  logic                     stall;
  logic                     we;
  logic [ADDR-1:0]          waddr;
  logic [DATA-1:0]          wdata;
  logic [$clog2(DEPTH):0]   count;
  logic [ADDR-1:0]          q_addr;
  logic                     q_hit;
  logic [DATA-1:0]          q_data;

  regfile_wbq #(.DATA(DATA), .ADDR(ADDR), .SRC(SRC), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
    .src_data(src_data), .src_ready(src_ready), .stall(stall), .we(we),
    .waddr(waddr), .wdata(wdata), .count(count), .q_addr(q_addr),
    .q_hit(q_hit), .q_data(q_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR-1:0] a;
    logic [DATA-1:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] wlog[$];
  int          checks = 0;
  int          failures = 0;

`ifdef REGFILE_WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, then retire the model.
  task automatic cycle();
    bit              e_pop;
    int              win;
    logic [SRC-1:0]  e_rdy;
    bit              e_hit;
    logic [DATA-1:0] e_qd;
    @(negedge clk);
    e_pop = reset && (mq.size() != 0) && !stall;
    win = -1;
    for (int i = 0; i < SRC; i++) if (src_valid[i] && win < 0) win = i;
    e_rdy = '0;
    if (reset && win >= 0 && (mq.size() < DEPTH || e_pop)) e_rdy[win] = 1'b1;
    e_hit = 1'b0;
    e_qd  = '0;
    if (FWD && reset && q_addr != 0) begin
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].a == q_addr) begin e_hit = 1'b1; e_qd = mq[i].d; end
    end
    chk("count", 64'(count), 64'(mq.size()));
    chk("we", 64'(we), 64'(e_pop));
    if (e_pop) begin
      chk("waddr", 64'(waddr), 64'(mq[0].a));
      chk("wdata", 64'(wdata), 64'(mq[0].d));
    end
    chk("src_ready", 64'(src_ready), 64'(e_rdy));
    chk("q_hit", 64'(q_hit), 64'(e_hit));
    chk("q_data", 64'(q_data), 64'(e_qd));
    @(posedge clk);
    #1;
    if (!reset) begin
      mq.delete();
    end else begin
      if (e_pop) begin
        wlog.push_back(mq[0].d);
        void'(mq.pop_front());
      end
      if (e_rdy != 0 && src_addr[win] != 0) mq.push_back('{a: src_addr[win], d: src_data[win]});
    end
  endtask

  task automatic idle();
    src_valid = '0;
    src_addr  = '0;
    src_data  = '0;
  endtask

  task automatic push0(input logic [ADDR-1:0] a, input logic [DATA-1:0] d);
    src_valid = 2'b01;
    src_addr[0] = a;
    src_data[0] = d;
  endtask

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    q_addr = '0;
    idle();
    src_valid = 2'b11;
    src_addr  = {4'd2, 4'd1};
    cycle();
    cycle();
    chk("rst_count", 64'(count), 64'd0);
    reset = 1'b1;
    idle();
    cycle();

    // Arbitration: both producers request, lower index wins first
    src_valid = 2'b11; src_addr = {4'd7, 4'd5}; src_data = {32'hB, 32'hA};
    wlog.delete();
    cycle();
    src_valid = 2'b10;
    cycle();
    idle();
    cycle();
    cycle();
    chk("arb_order0", 64'(wlog[0]), 64'hA);
    chk("arb_order1", 64'(wlog[1]), 64'hB);

    // Full queue under stall, then pop and push in the same cycle
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin push0(4'(i + 1), 32'h100 + 32'(i)); cycle(); end
    push0(4'd9, 32'h109);
    cycle();
    chk("full_count", 64'(count), 64'd4);
    stall = 1'b0;
    cycle();
    chk("full_pp_count", 64'(count), 64'd4);
    idle();
    for (int i = 0; i < 6; i++) cycle();

    // Reset while three entries wait: none may ever be written
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin push0(4'd4, 32'hDEAD0000 + 32'(i)); cycle(); end
    wlog.delete();
    reset = 1'b0;
    push0(4'd6, 32'h5);
    cycle();
    reset = 1'b1;
    stall = 1'b0;
    idle();
    chk("rst_mid_count", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++) cycle();
    chk("rst_nowrite", 64'(wlog.size()), 64'd0);

    // Zero register: acknowledged, never queued
    push0(4'd0, 32'hFF);
    cycle();
    idle();
    chk("zero_count", 64'(count), 64'd0);
    cycle();

    // Forwarding picks the youngest matching entry
    stall = 1'b1;
    push0(4'd3, 32'h11); cycle();
    push0(4'd3, 32'h22); cycle();
    idle();
    q_addr = 4'd3;
    cycle();
    chk("fwd_hit", 64'(q_hit), 64'(FWD));
    chk("fwd_data", 64'(q_data), FWD ? 64'h22 : 64'h0);
    q_addr = 4'd0;
    cycle();
    stall = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Wrap-around: ten back-to-back push/pop cycles
    wlog.delete();
    for (int i = 1; i <= 10; i++) begin push0(4'd8, 32'(i)); cycle(); end
    idle();
    for (int i = 0; i < 4; i++) cycle();
    chk("wrap_len", 64'(wlog.size()), 64'd10);
    for (int i = 0; i < 10 && i < wlog.size(); i++) chk("wrap_seq", 64'(wlog[i]), 64'(i + 1));

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 2) == 0);
      src_valid = 2'($urandom);
      src_addr  = {4'($urandom), 4'($urandom)};
      src_data  = {$urandom, $urandom};
      q_addr    = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
